// File: rtl/aes_pkg.sv
// Shared AES definitions: engine states, cipher dimensions, forward S-box and GF(2^8) doubling.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int NUM_ROUNDS = 10;
   localparam int KEY_ADDR_W = 4;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_encryption_if.sv
// Plaintext-in / ciphertext-out handshake plus round-key store port of the encryption engine.
interface aes_encryption_if;
   import aes_pkg::*;

   logic                  read_fifo;
   logic [127:0]          fifo_in;
   logic                  ready;
   logic [127:0]          round_key_0;
   logic [KEY_ADDR_W-1:0] round_key_addr;
   logic [127:0]          round_key_input;
   logic                  is_full;
   logic [127:0]          data_output;
   logic                  data_valid;

   modport master (
      output read_fifo, fifo_in, round_key_0, round_key_input, is_full,
      input  ready, round_key_addr, data_output, data_valid
   );

   modport slave (
      input  read_fifo, fifo_in, round_key_0, round_key_input, is_full,
      output ready, round_key_addr, data_output, data_valid
   );

endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] i_data,
   input  logic [127:0] i_key,
   input  logic         i_final,
   output logic [127:0] o_data
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   for (genvar i = 0; i < 16; i++) begin : g_sub
      assign sb[i] = sbox(i_data[127-8*i -: 8]);
   end

   // Byte 4c+r is s[r][c]; row r rotates left by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
      assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
   end

   for (genvar i = 0; i < 16; i++) begin : g_ark
      assign o_data[127-8*i -: 8] = (i_final ? sr[i] : mc[i]) ^ i_key[127-8*i -: 8];
   end

endmodule

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryption engine: initial AddRoundKey on accept, then one round per clock.
// Round keys come from an external store addressed combinationally by round_key_addr.
module aes_encryption
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   aes_encryption_if.slave bus
);

   state_t       state;
   logic [3:0]   round;
   logic [127:0] block;
   logic [127:0] data_out;
   logic         data_vld;
   logic [127:0] round_out;
   logic         final_round;
   logic         round_legal;

   assign final_round = (round == 4'(NUM_ROUNDS));
   assign round_legal = (round != 4'd0) && (round <= 4'(NUM_ROUNDS));

   aes_enc_round u_round (
      .i_data  (block),
      .i_key   (bus.round_key_input),
      .i_final (final_round),
      .o_data  (round_out)
   );

   assign bus.ready          = (state == IDLE);
   assign bus.round_key_addr = (state == ROUND) ? KEY_ADDR_W'(round) : '0;
   assign bus.data_output    = data_out;
   assign bus.data_valid     = data_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         round    <= '0;
         block    <= '0;
         data_out <= '0;
         data_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               data_vld <= 1'b0;
               if (bus.read_fifo) begin
                  block <= bus.fifo_in ^ bus.round_key_0;
                  round <= 4'd1;
                  state <= ROUND;
               end else begin
                  round <= '0;
               end
            end
            ROUND: begin
               if (!round_legal) begin
                  state <= IDLE;
                  round <= '0;
               end else if (final_round) begin
                  data_out <= round_out;
                  data_vld <= 1'b1;
                  round    <= '0;
                  state    <= DONE;
               end else begin
                  block <= round_out;
                  round <= round + 4'd1;
               end
            end
            DONE: begin
               // Ciphertext is held until the output FIFO has room.
               if (!bus.is_full) begin
                  data_vld <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               round    <= '0;
               data_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encryption.sv
// Directed and randomised bench for the iterative AES-128 encryption engine.
module tb_aes_encryption;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   logic [7:0]   tsb [256];
   logic [127:0] ks  [11];

   aes_encryption_if bus ();

   aes_encryption dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Key store with same-cycle read.
   assign bus.round_key_0     = ks[0];
   assign bus.round_key_input = (bus.round_key_addr <= 4'd10) ? ks[bus.round_key_addr] : '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from the field inverse and the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         tsb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {tsb[t[31:24]] ^ rc, tsb[t[23:16]], tsb[t[15:8]], tsb[t[7:0]]};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] pt);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] res;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ ks[0][127-8*(4*c+r) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = tsb[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 10) begin
               s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
               s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ ks[rnd][127-8*(4*c+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Present a block for one cycle; returns at the start of the first busy cycle.
   task automatic issue(input logic [127:0] pt);
      bus.read_fifo = 1'b1;
      bus.fifo_in   = pt;
      step();
      bus.read_fifo = 1'b0;
      bus.fifo_in   = '0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!bus.data_valid && n < budget) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, 128'(bus.data_valid), 128'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] exp;
      logic [127:0] pt;
      logic         full;
      logic         seen;
      int           n;

      rst           = 1'b1;
      bus.read_fifo = 1'b0;
      bus.fifo_in   = '0;
      bus.is_full   = 1'b0;
      build_sbox();
      load_key(KEY_B);
      step();
      step();
      check("rst_ready", 128'(bus.ready), 128'(1));
      check("rst_addr", 128'(bus.round_key_addr), 128'(0));
      check("rst_valid", 128'(bus.data_valid), 128'(0));
      check("rst_dout", bus.data_output, '0);
      rst = 1'b0;

      // App. B vector, key addresses 1..10 on the ten cycles after acceptance.
      check("b_ready", 128'(bus.ready), 128'(1));
      issue(PT_B);
      for (int i = 1; i <= 10; i++) begin
         check("b_addr", 128'(bus.round_key_addr), 128'(i));
         check("b_busy", 128'(bus.ready), 128'(0));
         check("b_early_valid", 128'(bus.data_valid), 128'(0));
         step();
      end
      check("b_valid", 128'(bus.data_valid), 128'(1));
      check("b_ct", bus.data_output, CT_B);
      check("b_done_addr", 128'(bus.round_key_addr), 128'(0));
      check("b_done_ready", 128'(bus.ready), 128'(0));
      step();
      check("b_release", 128'(bus.data_valid), 128'(0));
      check("b_idle", 128'(bus.ready), 128'(1));

      // App. C.1 vector, then a second block on the first ready cycle.
      load_key(KEY_C);
      issue(PT_C);
      n    = 1;
      seen = 1'b0;
      while (!bus.ready && n < 40) begin
         if (bus.data_valid && !seen) begin
            seen = 1'b1;
            check("c_valid_cycle", 128'(n), 128'(11));
            check("c_ct", bus.data_output, CT_C);
         end
         step();
         n++;
      end
      check("c_seen_valid", 128'(seen), 128'(1));
      check("c_reaccept_cycle", 128'(n), 128'(12));
      pt  = 128'hffeeddccbbaa99887766554433221100;
      exp = ref_enc(pt);
      issue(pt);
      wait_valid("c2", 20);
      check("c2_ct", bus.data_output, exp);
      step();

      // Back-pressure from cycle 8 to 17.
      load_key(KEY_B);
      issue(PT_B);
      for (int c = 1; c <= 19; c++) begin
         bus.is_full = (c >= 8 && c <= 17);
         if (c >= 11 && c <= 18) begin
            check("bp_valid", 128'(bus.data_valid), 128'(1));
            check("bp_ct", bus.data_output, CT_B);
            check("bp_busy", 128'(bus.ready), 128'(0));
         end
         if (c == 19) begin
            check("bp_ready", 128'(bus.ready), 128'(1));
            check("bp_release", 128'(bus.data_valid), 128'(0));
         end
         step();
      end
      bus.is_full = 1'b0;

      // read_fifo held with changing data while busy.
      load_key(KEY_C);
      issue(PT_C);
      for (int c = 1; c <= 10; c++) begin
         bus.read_fifo = 1'b1;
         bus.fifo_in   = rand128();
         check("ign_busy", 128'(bus.ready), 128'(0));
         step();
      end
      bus.read_fifo = 1'b0;
      bus.fifo_in   = '0;
      check("ign_valid", 128'(bus.data_valid), 128'(1));
      check("ign_ct", bus.data_output, CT_C);
      step();
      check("ign_ready", 128'(bus.ready), 128'(1));
      step();
      check("ign_no_accept", 128'(bus.ready), 128'(1));
      check("ign_no_valid", 128'(bus.data_valid), 128'(0));

      // Reset pulsed at cycle 5 of a block.
      load_key(KEY_B);
      issue(PT_B);
      for (int c = 1; c <= 4; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_ready", 128'(bus.ready), 128'(1));
      check("mid_rst_dout", bus.data_output, '0);
      check("mid_rst_valid", 128'(bus.data_valid), 128'(0));
      check("mid_rst_addr", 128'(bus.round_key_addr), 128'(0));
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (bus.data_valid) seen = 1'b1;
         step();
      end
      check("mid_rst_never_valid", 128'(seen), 128'(0));
      issue(PT_B);
      wait_valid("mid_rst_fresh", 15);
      check("mid_rst_fresh_ct", bus.data_output, CT_B);
      step();

      // Random keys and plaintexts with random output back-pressure.
      for (int t = 0; t < 1000; t++) begin
         load_key(rand128());
         pt  = rand128();
         exp = ref_enc(pt);
         bus.is_full = 1'($urandom_range(1));
         check("rnd_ready", 128'(bus.ready), 128'(1));
         issue(pt);
         for (int c = 1; c <= 10; c++) begin
            bus.is_full = 1'($urandom_range(1));
            step();
         end
         for (int j = 0; j < 8; j++) begin
            full        = (j < 7) ? 1'($urandom_range(1)) : 1'b0;
            bus.is_full = full;
            check("rnd_valid", 128'(bus.data_valid), 128'(1));
            check("rnd_ct", bus.data_output, exp);
            step();
            if (!full) break;
         end
         check("rnd_release", 128'(bus.data_valid), 128'(0));
         check("rnd_idle", 128'(bus.ready), 128'(1));
      end
      bus.is_full = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
